clarvi_slice_sequencer: RTL
===========================

CLARVI_SLICE_SEQUENCER -- requirements
Module: clarvi_slice_sequencer

Interface
REQ-001 Parameter: XLEN, 64, operand width; only 64 is legal (8 byte slices).
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  upstream offers an operation.
REQ-005 req_ready  out  1  sequencer can accept an operation this cycle.
REQ-006 req_order  in  2  slice order: 0 = ASC (0..7), 1 = DESC (7..0), 2 = SPLIT32 (3,2,1,0,7,6,5,4); 3 is reserved.
REQ-007 req_rs1  in  64  operand 1.
REQ-008 req_rs2  in  64  operand 2.
REQ-009 kill  in  1  abort the operation in flight.
REQ-010 alu_part  out  3  slice index driven to the byte ALU instr_part.
REQ-011 alu_rs1_byte  out  8  byte alu_part of the latched rs1.
REQ-012 alu_rs2_byte  out  8  byte alu_part of the latched rs2.
REQ-013 alu_stall  out  1  freezes the byte ALU carry/shift state register.
REQ-014 alu_result  in  8  byte result from the ALU for the current alu_part.
REQ-015 done_valid  out  1  rd_value is complete.
REQ-016 done_ready  in  1  downstream consumes rd_value.
REQ-017 rd_value  out  64  assembled 64-bit result.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-019 req_ready SHALL be 1 in IDLE, and 1 in DONE only when done_ready=1; it SHALL be 0 in RUN.
REQ-020 Accept: req_valid&&req_ready at an edge SHALL latch rs1, rs2 and order, clear rd_value, zero the step counter, and enter RUN.
REQ-021 In RUN, step k (0..7) SHALL drive alu_part = ASC: k; DESC: 7-k; SPLIT32: (k<4) ? 3-k : 11-k.
REQ-022 alu_rs1_byte and alu_rs2_byte SHALL be combinational byte selects of the latched operands at alu_part.
REQ-023 alu_stall SHALL be 0 in RUN and 1 in IDLE and DONE, so the ALU state advances exactly once per step.
REQ-024 At each RUN edge, rd_value[8*alu_part+:8] SHALL capture alu_result; other bytes SHALL hold their values.
REQ-025 Latency: after the step-7 edge the FSM SHALL enter DONE; done_valid SHALL be 1 exactly 8 cycles after the accept edge.
REQ-026 In DONE, rd_value and done_valid SHALL hold stable until done_ready=1.
REQ-027 If done_ready=1 in DONE and req_valid=0, the FSM SHALL enter IDLE at that edge.
REQ-028 If done_ready=1 and req_valid=1 in DONE, the old result SHALL be consumed and the new operation accepted at the same edge, with no bubble.
REQ-029 kill=1 in RUN SHALL force IDLE at the next edge with no done_valid; kill SHALL be ignored in IDLE and DONE; kill has priority over step advance.
REQ-030 req_order=3 SHALL be treated as ASC.
REQ-031 alu_part SHALL be 0 when not in RUN.
REQ-032 The step counter SHALL saturate at 7; RUN SHALL never wrap back to step 0.

Reset
REQ-033 reset_n=0 SHALL immediately and asynchronously set: state IDLE, req_ready=1, done_valid=0, alu_stall=1, alu_part=0, rd_value=0, step counter 0, and latched operands 0.
REQ-034 Reset asserted mid-RUN or in DONE SHALL discard the operation; after release, the next req_valid SHALL be accepted at the first edge.

Verification
REQ-035 Echo ALU (alu_result=alu_rs1_byte), ASC, rs1=0x0123456789ABCDEF -> alu_part 0..7 on consecutive cycles; done_valid 8 cycles after accept; rd_value=0x0123456789ABCDEF.
REQ-036 Echo ALU, DESC then SPLIT32, rs1=0xFEDCBA9876543210 -> parts 7..0, then 3,2,1,0,7,6,5,4; rd_value=0xFEDCBA9876543210 in both cases.
REQ-037 Real clarvi byte ALU, ADD 64-bit, rs1=0x00000000FFFFFFFF, rs2=1 -> rd_value=0x0000000100000000; SLT DESC, rs1=-1, rs2=0 -> rd_value=1.
REQ-038 done_ready held 0 for 5 cycles in DONE -> rd_value, done_valid=1 and alu_stall=1 stable for those cycles; req_ready=0.
REQ-039 Back-to-back: done_ready=1 and req_valid=1 in DONE -> next op's step-0 alu_part appears on the following cycle; second result is correct.
REQ-040 kill at step 4 -> IDLE next cycle, done_valid never asserted, new op accepted immediately; reset_n pulsed at step 2 -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/clarvi_slice_sequencer.sv
// clarvi_slice_sequencer: walks a byte-serial ALU across the 8 slices of a 64-bit
// operation in ASC, DESC or SPLIT32 order and assembles the result.
module clarvi_slice_sequencer #(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_order,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   input  logic            kill,
   output logic [2:0]      alu_part,
   output logic [7:0]      alu_rs1_byte,
   output logic [7:0]      alu_rs2_byte,
   output logic            alu_stall,
   input  logic [7:0]      alu_result,
   output logic            done_valid,
   input  logic            done_ready,
   output logic [XLEN-1:0] rd_value
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t          state;
   logic [2:0]      step;
   logic [1:0]      order;
   logic [XLEN-1:0] rs1, rs2;
   logic [2:0]      run_part;
   logic            accept;
   always_comb begin
      // SPLIT32 walks each 32-bit half downwards: low half first, then high half
      run_part     = order == 2'd1 ? ~step : order == 2'd2 ? {step[2], ~step[1:0]} : step;
      alu_part     = state == RUN ? run_part : 3'd0;
      alu_rs1_byte = rs1[{alu_part, 3'b000} +: 8];
      alu_rs2_byte = rs2[{alu_part, 3'b000} +: 8];
      alu_stall    = state != RUN;
      done_valid   = state == DONE;
      req_ready    = state == IDLE || (state == DONE && done_ready);
      accept       = req_valid && req_ready;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         step     <= 3'd0;
         order    <= 2'd0;
         rs1      <= '0;
         rs2      <= '0;
         rd_value <= '0;
      end else if (accept) begin
         state    <= RUN;
         step     <= 3'd0;
         order    <= req_order;
         rs1      <= req_rs1;
         rs2      <= req_rs2;
         rd_value <= '0;
      end else if (state == RUN) begin
         if (kill) begin
            state <= IDLE;
         end else begin
            rd_value[{run_part, 3'b000} +: 8] <= alu_result;
            step  <= step == 3'd7 ? step : step + 3'd1;
            state <= step == 3'd7 ? DONE : RUN;
         end
      end else if (state == DONE && done_ready) begin
         state <= IDLE;
      end
   end
endmodule
